pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_slot.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: payload widths,
// the bubble instruction encoding, and the control encodings used
// between a stage and its storage slots.
package pipe_pkg;

    // Instruction that the decoder treats as a bubble (no operation).
    localparam logic [31:0] BUBBLE_INST = 32'hffffffff;

    // Default stage payload layout is {pc, inst}.
    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int STAGE_W = PC_W + INST_W;

    // Action applied to a slot at the next capture edge.
    typedef enum logic [1:0] {
        SLOT_HOLD  = 2'd0,
        SLOT_LOAD  = 2'd1,
        SLOT_CLEAR = 2'd2
    } slot_op_e;

    // Where the head slot takes its next payload from.
    typedef enum logic {
        SRC_IN   = 1'b0,
        SRC_SKID = 1'b1
    } head_src_e;

    // Pack a program counter and an instruction into one stage payload.
    function automatic logic [STAGE_W-1:0] make_payload(
        input logic [PC_W-1:0]   pc,
        input logic [INST_W-1:0] inst
    );
        return {pc, inst};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: a valid bit plus its payload.
// A cleared or reset slot always carries the bubble payload, so anything
// reading the data of an empty slot sees a harmless value.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W = STAGE_W,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  slot_op_e          op,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Capture on the falling edge like the rest of the pipeline; reset empties the slot at once.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= BUBBLE;
        end else begin
            case (op)
                SLOT_LOAD: begin
                    valid <= 1'b1;
                    data  <= load_data;
                end
                SLOT_CLEAR: begin
                    valid <= 1'b0;
                    data  <= BUBBLE;
                end
                default: begin
                    valid <= valid;
                    data  <= data;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with an optional skid entry.
// M is the head entry that drives out_data. With SKID enabled a second
// entry S catches a payload that arrives while the head is blocked, which
// lets in_ready be computed from local state only and keeps the ready path
// from rippling combinationally through the whole pipeline.
// Without the skid entry the stage accepts a new payload in the same edge
// that the head leaves, so throughput stays at one per cycle but in_ready
// follows out_ready combinationally.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W = STAGE_W,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b1}},
    parameter int                SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    localparam bit HAS_SKID = (SKID != 0);

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;

    slot_op_e          m_op;
    slot_op_e          s_op;
    head_src_e         m_src;
    logic [DATA_W-1:0] m_din;

    logic              in_fire;
    logic              out_fire;
    logic              m_valid_nxt;
    logic              s_valid_nxt;
    logic [1:0]        occ_q;

    // Ready depends only on local state with a skid entry, or on downstream readiness without one.
    always_comb begin
        in_ready = 1'b0;
        if (HAS_SKID) begin
            in_ready = !stall && !s_valid;
        end else begin
            in_ready = !stall && (!m_valid || out_ready);
        end
    end

    assign out_valid = m_valid && !stall && !flush;
    assign out_data  = m_valid ? m_data : BUBBLE;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign m_din     = (m_src == SRC_SKID) ? s_data : in_data;
    assign occ       = occ_q;

    // Decide what each entry does at the next edge; flush beats everything and stall freezes the rest.
    always_comb begin
        m_op        = SLOT_HOLD;
        s_op        = SLOT_HOLD;
        m_src       = SRC_IN;
        m_valid_nxt = m_valid;
        s_valid_nxt = s_valid;

        if (flush) begin
            m_op        = SLOT_CLEAR;
            s_op        = SLOT_CLEAR;
            m_valid_nxt = 1'b0;
            s_valid_nxt = 1'b0;
        end else if (!stall) begin
            if (!m_valid) begin
                if (in_fire) begin
                    m_op        = SLOT_LOAD;
                    m_valid_nxt = 1'b1;
                end
            end else if (out_fire) begin
                if (s_valid) begin
                    m_op        = SLOT_LOAD;
                    m_src       = SRC_SKID;
                    s_op        = SLOT_CLEAR;
                    s_valid_nxt = 1'b0;
                end else if (in_fire) begin
                    m_op = SLOT_LOAD;
                end else begin
                    m_op        = SLOT_CLEAR;
                    m_valid_nxt = 1'b0;
                end
            end else if (in_fire && HAS_SKID) begin
                s_op        = SLOT_LOAD;
                s_valid_nxt = 1'b1;
            end
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_m_slot (
        .clk       (clk),
        .rst       (rst),
        .op        (m_op),
        .load_data (m_din),
        .valid     (m_valid),
        .data      (m_data)
    );

    if (HAS_SKID) begin : g_skid
        pipe_slot #(
            .DATA_W (DATA_W),
            .BUBBLE (BUBBLE)
        ) u_s_slot (
            .clk       (clk),
            .rst       (rst),
            .op        (s_op),
            .load_data (in_data),
            .valid     (s_valid),
            .data      (s_data)
        );
    end else begin : g_no_skid
        logic unused_s_op;
        assign unused_s_op = ^s_op;
        assign s_valid     = 1'b0;
        assign s_data      = BUBBLE;
    end

    // Occupancy is registered from the next-state valids so it lines up with the slots themselves.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= {1'b0, m_valid_nxt} + {1'b0, s_valid_nxt};
        end
    end

endmodule
